// File: rtl/pc_sequencer.sv
// 64-bit fetch-stage program counter: PC+4 or a PC-relative branch from PC-4.
// Optional macro PC_SEQ_TARGET_OUT_EN exports the branch target and next-PC values.

module pc_seq_addsub64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        sub_i,
    output logic [63:0] sum_o
);
    // Two's-complement subtract: invert b and inject the carry-in; carry-out is dropped.
    assign sum_o = a_i + (b_i ^ {64{sub_i}}) + {63'd0, sub_i};
endmodule

module pc_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [25:0] imm26,
    input  logic [18:0] imm19,
    input  logic        uncondBr,
    input  logic        brTaken,
`ifdef PC_SEQ_TARGET_OUT_EN
    output logic [63:0] br_target,
    output logic [63:0] pc_next,
`endif
    output logic [63:0] pc
);
    logic [63:0] pc_q;
    logic [63:0] pc_d;
    logic [63:0] imm_ext;
    logic [63:0] byte_off;
    logic [63:0] base;
    logic [63:0] target;
    logic [63:0] seq;

    assign imm_ext  = uncondBr ? {{38{imm26[25]}}, imm26} : {{45{imm19[18]}}, imm19};
    assign byte_off = imm_ext << 2;

    // The branch decision lags fetch by one stage, so the offset is relative to PC-4.
    pc_seq_addsub64 u_base (
        .a_i   (pc_q),
        .b_i   (64'd4),
        .sub_i (1'b1),
        .sum_o (base)
    );

    pc_seq_addsub64 u_target (
        .a_i   (base),
        .b_i   (byte_off),
        .sub_i (1'b0),
        .sum_o (target)
    );

    pc_seq_addsub64 u_seq (
        .a_i   (pc_q),
        .b_i   (64'd4),
        .sub_i (1'b0),
        .sum_o (seq)
    );

    always_comb begin
        pc_d = seq;
        if (brTaken) begin
            pc_d = target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

`ifdef PC_SEQ_TARGET_OUT_EN
    assign br_target = target;
    assign pc_next   = pc_d;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed PC sequences.
// Exercises the PC_SEQ_TARGET_OUT_EN ports when that macro is defined.

module tb_pc_sequencer;
    logic        clk;
    logic        reset;
    logic [25:0] imm26;
    logic [18:0] imm19;
    logic        uncondBr;
    logic        brTaken;
    logic [63:0] pc;
`ifdef PC_SEQ_TARGET_OUT_EN
    logic [63:0] br_target;
    logic [63:0] pc_next;
`endif

    int tests_run;
    int tests_failed;

    pc_sequencer #(.RESET_PC(64'h0)) dut (
        .clk      (clk),
        .reset    (reset),
        .imm26    (imm26),
        .imm19    (imm19),
        .uncondBr (uncondBr),
        .brTaken  (brTaken),
`ifdef PC_SEQ_TARGET_OUT_EN
        .br_target(br_target),
        .pc_next  (pc_next),
`endif
        .pc       (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: pc 0x%016h", tag, got);
        end
    endtask

    // Apply current inputs for one edge, then compare pc just after the edge.
    task automatic step(input string tag, input logic [63:0] exp_pc);
`ifdef PC_SEQ_TARGET_OUT_EN
        #1;
        if (!reset) begin
            check_eq({tag, ".pc_next"}, pc_next, exp_pc);
        end
`endif
        @(posedge clk);
        #1;
        check_eq(tag, pc, exp_pc);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        brTaken  = 1'b0;
        uncondBr = 1'b0;
        imm26    = '0;
        imm19    = '0;
        step("reset", 64'h0);
        reset = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset while a branch is requested: reset wins.
        reset    = 1'b1;
        brTaken  = 1'b1;
        uncondBr = 1'b1;
        imm26    = 26'd100;
        imm19    = 19'd7;
        step("reset_with_branch", 64'h0);

        reset   = 1'b0;
        brTaken = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step($sformatf("seq_%0d", i), 64'(i * 4));
        end

        // Conditional forward branch at 0x20.
        brTaken  = 1'b1;
        uncondBr = 1'b0;
        imm19    = 19'd11;
        imm26    = 26'd42;
`ifdef PC_SEQ_TARGET_OUT_EN
        #1;
        check_eq("cond_br.br_target", br_target, 64'h48);
`endif
        step("cond_br", 64'h48);

        uncondBr = 1'b1;
        step("uncond_br", 64'hEC);

        // uncondBr left high but ignored without brTaken.
        brTaken = 1'b0;
        step("seq_after_br", 64'hF0);

        // Backward branches from 0x10.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step($sformatf("to10_%0d", i), 64'(i * 4));
        end
        brTaken  = 1'b1;
        uncondBr = 1'b0;
        imm19    = 19'h7FFFF;
        step("back_imm19", 64'h8);
        brTaken = 1'b0;
        step("back_seq_c", 64'hC);
        step("back_seq_10", 64'h10);
        brTaken  = 1'b1;
        uncondBr = 1'b1;
        imm26    = 26'h3FFFFFE;
        step("back_imm26", 64'h4);

        // Largest positive imm19 from pc=4 (base 0).
        uncondBr = 1'b0;
        imm19    = 19'h3FFFF;
        step("imm19_max", 64'hFFFFC);

        // Reset priority at pc=0x100 with a pending branch.
        do_reset();
        for (int i = 1; i <= 64; i++) begin
            step($sformatf("to100_%0d", i), 64'(i * 4));
        end
`ifdef PC_SEQ_TARGET_OUT_EN
        brTaken  = 1'b1;
        uncondBr = 1'b0;
        imm19    = 19'd5;
        #1;
        check_eq("rst_prio.br_target", br_target, 64'h110);
`endif
        reset    = 1'b1;
        brTaken  = 1'b1;
        uncondBr = 1'b0;
        imm19    = 19'd5;
        step("rst_prio", 64'h0);
        reset   = 1'b0;
        brTaken = 1'b0;
        step("rst_release", 64'h4);

        // Wrap-around: base of pc=0 is 0xFFFF_FFFF_FFFF_FFFC.
        do_reset();
        brTaken  = 1'b1;
        uncondBr = 1'b0;
        imm19    = 19'd0;
        step("wrap_base", 64'hFFFF_FFFF_FFFF_FFFC);
        brTaken = 1'b0;
        step("wrap_seq", 64'h0);

        // Most negative imm26 from pc=0: -4 - 2^27.
        brTaken  = 1'b1;
        uncondBr = 1'b1;
        imm26    = 26'h2000000;
        step("imm26_min", 64'hFFFF_FFFF_F7FF_FFFC);
        brTaken = 1'b0;
        step("imm26_min_seq", 64'hFFFF_FFFF_F800_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end
endmodule
